// File: rtl/lcd_write_sequencer.sv
// rtl/lcd_write_sequencer.sv - HD44780 character LCD write sequencer with one-deep pending buffer
module lcd_write_sequencer #(
  parameter int T_SETUP_CYC = 2,
  parameter int T_PW_CYC    = 12,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_EXEC_CYC  = 2000,
  parameter int T_LONG_CYC  = 82000,
  parameter int CNT_W       = 20
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] io_lcd_i,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o,
  output logic [31:0] lcd_status_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  // Counter reload values: each phase lasts exactly its duration in cycles.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PW_LD    = CNT_W'(T_PW_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(T_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(T_LONG_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tog_q;
  logic             req;
  logic             load_act;
  logic             wait_done;
  logic             long_cmd;
  logic             cnt_zero;
  logic             act_rs_q;
  logic [7:0]       act_data_q;
  logic             pend_v_q;
  logic             pend_rs_q;
  logic [7:0]       pend_data_q;
  logic             ovr_q;
  logic [7:0]       done_q;
  logic             on_q;
  logic [31:0]      status_q;
  logic             unused_io;

  // Software signals a new request by flipping bit 30; bits not decoded here are ignored.
  assign req       = io_lcd_i[30] ^ tog_q;
  assign unused_io = ^{io_lcd_i[28:10], io_lcd_i[8]};

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  assign long_cmd = !act_rs_q && ((act_data_q == 8'h01) || (act_data_q[7:1] == 7'b0000001));
  assign cnt_zero = (cnt_q == '0);

  // State register and shared phase down-counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: reload the counter on every phase entry, advance when it hits zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_act  = 1'b0;
    wait_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_v_q || req) begin
          state_d  = S_SETUP;
          cnt_d    = SETUP_LD;
          load_act = 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_PULSE;
          cnt_d   = PW_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt_zero) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          state_d = S_WAIT;
          cnt_d   = long_cmd ? LONG_LD : EXEC_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt_zero) begin
          state_d   = S_IDLE;
          wait_done = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Toggle copy for edge detection and registered panel power.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tog_q <= 1'b0;
      on_q  <= 1'b0;
    end else begin
      tog_q <= io_lcd_i[30];
      on_q  <= io_lcd_i[31];
    end
  end

  // Active byte driven onto the pins; the pending entry is older, so it goes first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_rs_q   <= 1'b0;
      act_data_q <= 8'h00;
    end else if (load_act) begin
      if (pend_v_q) begin
        act_rs_q   <= pend_rs_q;
        act_data_q <= pend_data_q;
      end else begin
        act_rs_q   <= io_lcd_i[9];
        act_data_q <= io_lcd_i[7:0];
      end
    end
  end

  // One-deep pending buffer: drained in IDLE, refilled by a request arriving that same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_v_q    <= 1'b0;
      pend_rs_q   <= 1'b0;
      pend_data_q <= 8'h00;
    end else if (state_q == S_IDLE) begin
      if (pend_v_q) begin
        pend_v_q <= req;
        if (req) begin
          pend_rs_q   <= io_lcd_i[9];
          pend_data_q <= io_lcd_i[7:0];
        end
      end
    end else if (req && !pend_v_q) begin
      pend_v_q    <= 1'b1;
      pend_rs_q   <= io_lcd_i[9];
      pend_data_q <= io_lcd_i[7:0];
    end
  end

  // Sticky overrun: a dropped request beats a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovr_q <= 1'b0;
    end else if (req && pend_v_q && (state_q != S_IDLE)) begin
      ovr_q <= 1'b1;
    end else if (io_lcd_i[29]) begin
      ovr_q <= 1'b0;
    end
  end

  // Completed-transfer count, wrapping at 256.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= 8'h00;
    end else if (wait_done) begin
      done_q <= done_q + 8'h01;
    end
  end

  // Registered status word read back by software.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q <= 32'h0;
    end else begin
      status_q <= {16'h0, done_q, 5'h0, ovr_q, pend_v_q, (state_q != S_IDLE)};
    end
  end

  assign lcd_data_o   = act_data_q;
  assign lcd_rs_o     = act_rs_q;
  assign lcd_rw_o     = 1'b0;
  assign lcd_en_o     = (state_q == S_PULSE);
  assign lcd_on_o     = on_q;
  assign lcd_status_o = status_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// tb/tb_lcd_write_sequencer.sv - scoreboard bench for lcd_write_sequencer
module tb_lcd_write_sequencer;

  localparam int TS = 2;
  localparam int TP = 4;
  localparam int TH = 2;
  localparam int TE = 10;
  localparam int TL = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] io_lcd = 32'h0;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on;
  logic [31:0] lcd_status;

  lcd_write_sequencer #(
    .T_SETUP_CYC(TS), .T_PW_CYC(TP), .T_HOLD_CYC(TH),
    .T_EXEC_CYC(TE), .T_LONG_CYC(TL), .CNT_W(20)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .io_lcd_i(io_lcd),
    .lcd_data_o(lcd_data), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw),
    .lcd_en_o(lcd_en), .lcd_on_o(lcd_on), .lcd_status_o(lcd_status)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  typedef struct { logic rs; logic [7:0] data; int edge_no; } pulse_t;
  typedef struct { logic [31:0] status; logic on; } stat_t;

  pulse_t pulse_q[$];
  stat_t  stat_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: remaining busy cycles of the current transfer plus the pending slot.
  int       m_rem = 0;
  bit       m_pv = 0;
  bit       m_prs = 0;
  bit [7:0] m_pd = 0;
  bit       m_ovr = 0;
  bit [7:0] m_cnt = 0;
  bit       tog = 0;
  bit       on_bit = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int dur(input bit rs, input bit [7:0] d);
    bit is_long;
    is_long = !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    return TS + TP + TH + (is_long ? TL : TE);
  endfunction

  task automatic model_start(input bit rs, input bit [7:0] d);
    m_rem = dur(rs, d);
    pulse_q.push_back('{rs, d, cyc + TS});
  endtask

  task automatic model_clear();
    m_rem = 0; m_pv = 0; m_prs = 0; m_pd = 0; m_ovr = 0; m_cnt = 0;
    tog = 0; on_bit = 0;
    pulse_q.delete();
    stat_q.delete();
  endtask

  // One clock: drive inputs, take the edge, advance the model, queue the expected status.
  task automatic step(input bit tg, input bit rs, input bit [7:0] d, input bit clr);
    if (tg) tog = ~tog;
    io_lcd = {on_bit, tog, clr, 19'h0, rs, 1'b0, d};
    @(posedge clk);
    cyc++;
    stat_q.push_back('{{16'h0, m_cnt, 5'h0, m_ovr, m_pv, (m_rem > 0)}, on_bit});
    if (m_rem == 0) begin
      if (m_pv) begin
        model_start(m_prs, m_pd);
        m_pv = tg;
        if (tg) begin m_prs = rs; m_pd = d; end
      end else if (tg) begin
        model_start(rs, d);
      end
      if (clr) m_ovr = 0;
    end else begin
      m_rem--;
      if (m_rem == 0) m_cnt++;
      if (tg && m_pv) begin
        m_ovr = 1;
      end else begin
        if (tg) begin m_pv = 1; m_prs = rs; m_pd = d; end
        if (clr) m_ovr = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0);
  endtask

  task automatic drain();
    while (m_rem > 0 || m_pv) step(0, 0, 8'h00, 0);
    idle(2);
  endtask

  task automatic run_count(input int n, output int busy);
    busy = 0;
    for (int i = 0; i < n; i++) begin
      step(0, 0, 8'h00, 0);
      if (lcd_status[0]) busy++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    io_lcd = 32'h0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares status every cycle and each EN pulse against the scoreboard.
  logic       prev_en = 0;
  int         w = 0;
  int         hold_left = 0;
  logic       h1_rs = 0, h2_rs = 0, pv_rs = 0;
  logic [7:0] h1_d = 0, h2_d = 0, pv_d = 0;
  stat_t      mon_s;
  pulse_t     mon_p;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 0; w = 0; hold_left = 0;
    end else begin
      if (stat_q.size() > 0) begin
        mon_s = stat_q.pop_front();
        check("status", lcd_status, mon_s.status);
        check("lcd_on", {31'h0, lcd_on}, {31'h0, mon_s.on});
      end
      if (lcd_en && !prev_en) begin
        check("pulse_expected", {31'h0, pulse_q.size() != 0}, 32'h1);
        if (pulse_q.size() != 0) begin
          mon_p = pulse_q.pop_front();
          check("pulse_rs", {31'h0, lcd_rs}, {31'h0, mon_p.rs});
          check("pulse_data", {24'h0, lcd_data}, {24'h0, mon_p.data});
          check("pulse_rise_edge", cyc, mon_p.edge_no);
        end
        check("setup_stable", {14'h0, h2_rs, h2_d, h1_rs, h1_d}, {14'h0, lcd_rs, lcd_data, lcd_rs, lcd_data});
        pv_rs = lcd_rs; pv_d = lcd_data; w = 0;
      end
      if (lcd_en) w++;
      if (!lcd_en && prev_en) begin
        check("en_width", w, TP);
        hold_left = TH;
      end
      if (hold_left > 0) begin
        check("hold_stable", {23'h0, lcd_rs, lcd_data}, {23'h0, pv_rs, pv_d});
        hold_left--;
      end
      h2_rs = h1_rs; h2_d = h1_d;
      h1_rs = lcd_rs; h1_d = lcd_data;
      prev_en = lcd_en;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  busy;
    bit  found;
    bit  rtg, rrs, rclr;
    bit [7:0] rd;

    // Reset values
    do_reset();
    check("rst_en", {31'h0, lcd_en}, 32'h0);
    check("rst_data", {24'h0, lcd_data}, 32'h0);
    check("rst_rs", {31'h0, lcd_rs}, 32'h0);
    check("rst_rw", {31'h0, lcd_rw}, 32'h0);
    check("rst_on", {31'h0, lcd_on}, 32'h0);
    check("rst_status", lcd_status, 32'h0);

    // Single data write, then clear display and a normal command
    step(1, 1, 8'h41, 0);
    run_count(30, busy);
    check("busy_data", busy, 18);
    check("count_after_one", {24'h0, lcd_status[15:8]}, 32'h1);
    step(1, 0, 8'h01, 0);
    run_count(50, busy);
    check("busy_clear", busy, 38);
    step(1, 0, 8'h38, 0);
    run_count(30, busy);
    check("busy_func_set", busy, 18);

    // Back-to-back: second toggle five cycles after the first
    do_reset();
    step(1, 1, 8'h41, 0);
    idle(4);
    step(1, 1, 8'h42, 0);
    step(0, 0, 8'h00, 0);
    check("b2b_pending", {31'h0, lcd_status[1]}, 32'h1);
    check("b2b_no_ovr", {31'h0, lcd_status[2]}, 32'h0);
    drain();
    check("b2b_count", {24'h0, lcd_status[15:8]}, 32'h2);

    // Overrun: three requests inside the first transfer, then clear
    do_reset();
    step(1, 1, 8'h41, 0);
    idle(2);
    step(1, 1, 8'h42, 0);
    idle(2);
    step(1, 1, 8'h43, 0);
    idle(2);
    check("ovr_set", {31'h0, lcd_status[2]}, 32'h1);
    drain();
    check("ovr_two_pulses", lcd_status[15:8], 32'h2);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    check("ovr_cleared", {31'h0, lcd_status[2]}, 32'h0);

    // Reset in the middle of the EN pulse with a pending entry
    do_reset();
    step(1, 1, 8'h55, 0);
    step(1, 1, 8'h66, 0);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (lcd_en) begin found = 1; break; end
      step(0, 0, 8'h00, 0);
    end
    check("midpulse_en_seen", {31'h0, found}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midpulse_en_async", {31'h0, lcd_en}, 32'h0);
    check("midpulse_status", lcd_status, 32'h0);
    do_reset();
    idle(60);
    check("midpulse_idle", lcd_status, 32'h0);

    // Done count wraps after 256 transfers
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(1, 1, 8'($urandom_range(32, 126)), 0);
      drain();
    end
    check("count_wrap0", {24'h0, lcd_status[15:8]}, 32'h0);
    step(1, 1, 8'h5a, 0);
    drain();
    check("count_wrap1", {24'h0, lcd_status[15:8]}, 32'h1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rtg  = ($urandom_range(0, 9) == 0);
      rrs  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: rd = 8'h01;
        1: rd = 8'h02;
        default: rd = 8'($urandom);
      endcase
      rclr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) on_bit = ~on_bit;
      step(rtg, rrs, rd, rclr);
    end
    drain();
    check("all_pulses_seen", pulse_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_write_sequencer.md
# lcd_write_sequencer

Sequencer on the peripheral side of the core's memory-mapped LCD output register. Software writes a command or data byte plus a request-toggle bit to the LCD output word; this block detects the request and drives the HD44780-compatible character LCD pins with correct setup, enable-pulse and hold timing. It then waits out the controller's execution time. A one-deep pending buffer absorbs one request issued while busy. A status word reports busy/pending/overrun and a transfer count, and is routed back to the load path as a readable input word.

## Interface
Parameters:
- T_SETUP_CYC, 2: cycles RS/DATA are stable before EN rises (≥40 ns at 50 MHz).
- T_PW_CYC, 12: EN high width in cycles (≥230 ns).
- T_HOLD_CYC, 2: cycles RS/DATA are held after EN falls.
- T_EXEC_CYC, 2000: post-write wait for normal commands/data (40 µs).
- T_LONG_CYC, 82000: post-write wait for clear/home (1.64 ms).
- CNT_W, 20: wait-counter width; must hold max(T_*)−1.

Ports:
- clk_i, input, 1: single clock.
- rst_ni, input, 1: reset; asynchronous, active-low.
- io_lcd_i, input, 32: the core's LCD output word. [31] on, [30] request toggle, [29] overrun clear (level), [9] rs, [7:0] data; other bits ignored.
- lcd_data_o, output, 8: LCD data bus.
- lcd_rs_o, output, 1: register select.
- lcd_rw_o, output, 1: tied 0 (write-only).
- lcd_en_o, output, 1: enable strobe.
- lcd_on_o, output, 1: panel power.
- lcd_status_o, output, 32: [0] busy, [1] pending, [2] overrun, [15:8] done count; other bits 0.

## Operation
- Request detection: a request is flagged whenever io_lcd_i[30] differs from a registered copy of it, taken on the prior cycle. The copy resets to 0.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT.
- IDLE, on a request or a valid pending entry:
  - latch rs/data into the active register, with pending taking priority over a new request;
  - go to SETUP.
- SETUP → PULSE after T_SETUP_CYC cycles.
- PULSE → HOLD after T_PW_CYC cycles. lcd_en_o=1 only in PULSE.
- HOLD → WAIT after T_HOLD_CYC cycles.
- WAIT → IDLE after T_EXEC_CYC cycles, or after T_LONG_CYC cycles for a long command (rs=0 and data[7:1]==7'b0000000 with data[0]=1, or data[7:1]==7'b0000001).
- The done count increments mod 256 on the WAIT exit.
- Single down-counter, loaded with (duration−1) on each state entry; the state advances when it reaches 0.
- lcd_data_o/lcd_rs_o always show the active register and keep the last value in IDLE.
- busy = (state != IDLE).
- Request while busy:
  - pending empty → store it in pending, set pending=1;
  - pending full → drop the new request and set overrun (sticky). The older pending entry is kept.
- Overrun clears while io_lcd_i[29]=1. If a set and a clear happen in the same cycle, the set wins.
- lcd_on_o = io_lcd_i[31], registered.

## Timing
- Reset (asynchronous) values: state IDLE; lcd_en_o, lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_on_o all 0; status 0; pending and toggle copy cleared.
- Reset mid-transfer: EN drops immediately and any pending entry is lost.
- Request sampled at edge k:
  - SETUP from k+1, and busy=1 from k+1;
  - EN rises at edge k+1+T_SETUP_CYC;
  - total busy time = T_SETUP_CYC+T_PW_CYC+T_HOLD_CYC+wait.
- When WAIT exits with pending valid, the FSM passes through IDLE for exactly 1 cycle and then enters SETUP.
  - A new request arriving in that IDLE cycle goes to pending.
- lcd_on_o lags io_lcd_i[31] by 1 cycle.
- The status word is registered and reflects state as of the previous edge.

## Test plan
- Bench parameters: T_SETUP_CYC=2, T_PW_CYC=4, T_HOLD_CYC=2, T_EXEC_CYC=10, T_LONG_CYC=30.
- Data write: toggle bit30 with rs=1, data=8'h41 → EN high for exactly 4 cycles starting 3 cycles after the toggle edge; rs=1 and data=0x41 stable 2 cycles before and after EN; busy for 18 cycles; count 0→1.
- Clear display: rs=0, data=8'h01 → busy 38 cycles. Then data=8'h38 → busy 18 cycles.
- Back-to-back: second toggle (data 8'h42) 5 cycles after the first → pending=1, no overrun; two EN pulses in order 0x41 then 0x42; count=2.
- Overrun: three toggles within the first transfer → overrun=1, only the first two bytes are emitted. Then bit29=1 for 1 cycle → overrun=0.
- Reset mid-PULSE: rst_ni low while EN=1 → EN=0 with no clock edge; status=0; no further pulse after reset releases.
- Count wrap: 256 transfers → count reads 0x00, and the next transfer reads 0x01.
